// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_pkg
//  Purpose  : Shared constants and types for the matrix multiplier result
//             path (matrix dimension, element width, frame header byte and
//             the result-streamer state encoding).
//  Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int         MAT_N     = 10;
    localparam int         MAT_W     = 8;
    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } strm_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_result_streamer
//  Purpose  : Snapshots the flattened N x N result matrix on each rising edge
//             of done and streams it as one byte-wide frame:
//             header, element bytes (row-major, LSB first), 8-bit checksum.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             c_flat            - result matrix, element (i,j) at
//                                 c_flat[(i*N+j)*W +: W]
//             done              - multiplier completion level
//             tx_data/tx_valid  - byte stream towards the transmitter
//             tx_ready          - transmitter accepts when valid && ready
//             busy              - frame captured or in flight
//             frame_done        - one-cycle pulse after checksum accepted
//             overrun           - sticky, done edge seen while busy
//  Revision : 1.0 - initial release
// ============================================================================
module matrix_result_streamer #(
    parameter int         N   = matrix_pkg::MAT_N,
    parameter int         W   = matrix_pkg::MAT_W,
    parameter logic [7:0] HDR = matrix_pkg::FRAME_HDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*N*W-1:0] c_flat,
    input  logic             done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    // The module parameter HDR shares its name with the header state, so the
    // states are imported individually and the header state gets an alias.
    import matrix_pkg::strm_state_t;
    import matrix_pkg::IDLE;
    import matrix_pkg::DATA;
    import matrix_pkg::CSUM;

    localparam strm_state_t ST_HDR = matrix_pkg::HDR;

    localparam int BPE    = W / 8;
    localparam int NBYTES = N * N * BPE;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    strm_state_t        state;
    strm_state_t        next_state;
    logic               done_q;
    logic               done_rise;
    logic [N*N*W-1:0]   shadow;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         csum;
    logic [7:0]         cur_byte;

    // Element e byte k sits at bit (e*BPE + k)*8, i.e. the running byte
    // index times eight, so one linear index walks the whole frame body.
    assign cur_byte  = shadow[{idx, 3'b000} +: 8];
    assign done_rise = done && !done_q;
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                if (done_rise) begin
                    next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (tx_ready) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready && (idx == LAST_IDX)) begin
                    next_state = CSUM;
                end
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, byte index, checksum and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            shadow     <= '0;
            idx        <= '0;
            csum       <= 8'h00;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            done_q     <= done;
            frame_done <= (state == CSUM) && tx_ready;

            if (done_rise) begin
                if (state == IDLE) begin
                    shadow  <= c_flat;
                    idx     <= '0;
                    csum    <= 8'h00;
                    overrun <= 1'b0;
                end else begin
                    // Includes the cycle of the checksum handshake: the
                    // state is still CSUM, so the edge is lost.
                    overrun <= 1'b1;
                end
            end

            if ((state == DATA) && tx_ready) begin
                csum <= csum + cur_byte;
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_result_streamer
//  Purpose  : Self-checking bench for matrix_result_streamer. Frame vectors
//             come from a table of {fill pattern, backpressure, checksum};
//             overrun, reset and the 2x2/16-bit configuration are directed
//             sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_result_streamer;

    // ---------------- default configuration DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic [799:0] c_flat;
    logic         done;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    matrix_result_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_flat     (c_flat),
        .done       (done),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // ---------------- N=2, W=16 DUT ----------------
    logic         rst2_n;
    logic [63:0]  c2;
    logic         done2;
    logic [7:0]   txd2;
    logic         txv2;
    logic         ready2;
    logic         busy2;
    logic         fd2;
    logic         ovr2;

    matrix_result_streamer #(.N(2), .W(16), .HDR(8'hA5)) dut2 (
        .clk        (clk),
        .rst_n      (rst2_n),
        .c_flat     (c2),
        .done       (done2),
        .tx_data    (txd2),
        .tx_valid   (txv2),
        .tx_ready   (ready2),
        .busy       (busy2),
        .frame_done (fd2),
        .overrun    (ovr2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got[$];
    int         fd_at;
    int         stable_err;
    bit         timed_out;

    typedef struct {
        int         fill;   // 0: e+1, 1: zeros, 2: 0xFF, 3: e
        bit         bp;     // random tx_ready backpressure
        logic [7:0] csum;   // hand-computed checksum
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int fill, input int e);
        case (fill)
            0:       return 8'(e + 1);
            1:       return 8'h00;
            2:       return 8'hFF;
            default: return 8'(e);
        endcase
    endfunction

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    task automatic load_c(input int fill);
        for (int e = 0; e < 100; e++) c_flat[e*8 +: 8] = model_byte(fill, e);
    endtask

    task automatic trigger(input int fill);
        @(negedge clk);
        load_c(fill);
        tx_ready = 1'b1;
        done     = 1'b1;
    endtask

    // Samples on falling edges. A byte is recorded when it is presented with
    // tx_ready high, i.e. it will be taken on the following rising edge.
    task automatic collect(input bit bp, input int inject_at, input int inject_fill,
                           input int abort_at);
        logic [7:0] held;
        bit         holding;
        bit         pushed;
        int         cyc;
        holding    = 1'b0;
        held       = 8'h00;
        cyc        = 0;
        got.delete();
        fd_at      = -1;
        stable_err = 0;
        timed_out  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (holding && !(tx_valid && tx_data == held)) stable_err++;
            if (frame_done) begin
                fd_at = cyc;
                break;
            end
            if (cyc > 2000) begin
                timed_out = 1'b1;
                break;
            end
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            pushed   = 1'b0;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                pushed = 1'b1;
            end
            holding = tx_valid && !tx_ready;
            held    = tx_data;
            if (pushed && inject_at > 0) begin
                if (got.size() == inject_at - 5) done = 1'b0;
                if (got.size() == inject_at) begin
                    load_c(inject_fill);
                    done = 1'b1;
                end
            end
            if (pushed && abort_at > 0 && got.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("reset drops tx_valid", 32'(tx_valid), 32'd0);
                check("reset drops busy", 32'(busy), 32'd0);
                break;
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic verify_frame(input string pfx, input int fill, input bit bp,
                                input logic [7:0] csum);
        int errs;
        errs = 0;
        check({pfx, " timeout"}, 32'(timed_out), 32'd0);
        check({pfx, " byte count"}, 32'(got.size()), 32'd102);
        check({pfx, " header"}, 32'(got_at(0)), 32'hA5);
        for (int e = 0; e < 100; e++) begin
            if (got_at(e + 1) !== model_byte(fill, e)) begin
                if (errs == 0)
                    $display("FAIL %s byte %0d: got 0x%0h, expected 0x%0h",
                             pfx, e, got_at(e + 1), model_byte(fill, e));
                errs++;
            end
        end
        check({pfx, " data byte errors"}, 32'(errs), 32'd0);
        check({pfx, " checksum"}, 32'(got_at(101)), 32'(csum));
        if (!bp) check({pfx, " frame_done cycle"}, 32'(fd_at), 32'd103);
        check({pfx, " hold stability"}, 32'(stable_err), 32'd0);
        @(negedge clk);
        check({pfx, " frame_done one cycle"}, 32'(frame_done), 32'd0);
        check({pfx, " busy after frame"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_quiet(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx_valid || frame_done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    logic [7:0] exp2[10];

    initial begin
        vecs[0] = '{fill: 0, bp: 1'b0, csum: 8'hBA};
        vecs[1] = '{fill: 1, bp: 1'b0, csum: 8'h00};
        vecs[2] = '{fill: 2, bp: 1'b1, csum: 8'h9C};
        vecs[3] = '{fill: 3, bp: 1'b1, csum: 8'h56};
        exp2    = '{8'hA5, 8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h08, 8'h07, 8'h24};

        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        done     = 1'b0;
        done2    = 1'b0;
        tx_ready = 1'b0;
        ready2   = 1'b1;
        c_flat   = '0;
        c2       = '0;

        repeat (2) @(negedge clk);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle without edge", 32'(tx_valid), 32'd0);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 4; v++) begin
            trigger(vecs[v].fill);
            collect(vecs[v].bp, 0, 0, 0);
            verify_frame($sformatf("vec%0d", v), vecs[v].fill, vecs[v].bp, vecs[v].csum);
            check($sformatf("vec%0d overrun", v), 32'(overrun), 32'd0);
            done = 1'b0;
            @(negedge clk);
        end

        // ---------------- overrun during DATA ----------------
        trigger(0);
        collect(1'b0, 30, 1, 0);
        verify_frame("overrun data", 0, 1'b0, 8'hBA);
        check("overrun set", 32'(overrun), 32'd1);
        expect_quiet("no second frame after overrun");
        check("overrun sticky", 32'(overrun), 32'd1);
        done = 1'b0;
        @(negedge clk);
        trigger(1);
        collect(1'b0, 0, 0, 0);
        verify_frame("after overrun", 1, 1'b0, 8'h00);
        check("overrun cleared by capture", 32'(overrun), 32'd0);
        done = 1'b0;
        @(negedge clk);

        // ---------------- edge coinciding with checksum handshake ----------------
        trigger(3);
        collect(1'b0, 102, 2, 0);
        verify_frame("csum edge", 3, 1'b0, 8'h56);
        check("csum edge overrun", 32'(overrun), 32'd1);
        expect_quiet("csum edge dropped");

        // ---------------- reset mid-frame, done held high ----------------
        done = 1'b0;
        @(negedge clk);
        trigger(0);
        collect(1'b0, 0, 0, 40);
        begin
            int fds;
            fds = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (frame_done || tx_valid) fds++;
            end
            check("no frame_done under reset", 32'(fds), 32'd0);
            check("overrun cleared by reset", 32'(overrun), 32'd0);
        end
        rst_n = 1'b1;
        collect(1'b0, 0, 0, 0);
        verify_frame("restart after reset", 0, 1'b0, 8'hBA);
        done = 1'b0;
        @(negedge clk);

        // ---------------- N=2, W=16 ----------------
        @(negedge clk);
        c2    = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
        done2 = 1'b1;
        begin
            logic [7:0] g2[$];
            int         cyc;
            bit         fd_seen;
            fd_seen = 1'b0;
            cyc     = 0;
            while (!fd_seen && cyc < 50) begin
                @(negedge clk);
                cyc++;
                if (fd2) fd_seen = 1'b1;
                else if (txv2 && ready2) g2.push_back(txd2);
            end
            check("w16 frame_done seen", 32'(fd_seen), 32'd1);
            check("w16 byte count", 32'(g2.size()), 32'd10);
            for (int i = 0; i < 10; i++)
                check($sformatf("w16 byte %0d", i),
                      32'((i < g2.size()) ? g2[i] : 8'hxx), 32'(exp2[i]));
            check("w16 overrun", 32'(ovr2), 32'd0);
            check("w16 busy after frame", 32'(busy2), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
